// File: rtl/dpram_drain.sv
// dpram_drain
//   Consumer side of the waveform-buffer DPRAM handshake. When the reader
//   pulses dpram_run, the block raises dpram_busy and reads words
//   0..len-1 from the DPRAM. It streams them as a length-prefixed frame of
//   16-bit halfwords, high half first. It then drops dpram_busy so the
//   reader can refill the DPRAM.
//
// Ports
//   clk, rst_n      : clock, asynchronous active-low reset
//   dpram_run       : one-cycle start pulse (only honoured when idle)
//   dpram_len       : frame length in 32-bit words, sampled with dpram_run
//   dpram_busy      : high from the cycle after run until the frame is done
//   dpram_rd_addr   : DPRAM read address
//   dpram_rd_data   : DPRAM read data, one cycle after the address
//   out_data/out_valid/out_ready/out_last : halfword stream (valid/ready)
//   frame_cnt       : completed-frame counter, wraps at 16 bits
module dpram_drain #(
  parameter int P_DPRAM_ADR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         dpram_run,
  input  logic [15:0]                  dpram_len,
  output logic                         dpram_busy,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
  input  logic [31:0]                  dpram_rd_data,
  output logic [15:0]                  out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [15:0]                  frame_cnt
);

  localparam int AW = P_DPRAM_ADR_WIDTH;
  // One extra bit so a full-depth length (2^AW) is representable.
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH = {1'b1, {AW{1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_RD, S_LAT, S_HI, S_LO, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [31:0]     word_q, word_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;
  logic [15:0]     data_q, data_d;
  logic            last_q, last_d;
  logic [15:0]     frame_q, frame_d;

  logic [LW-1:0]   len_clamp;
  logic [LW-1:0]   cnt_inc;
  logic            hs;

  // Lengths beyond the DPRAM depth are clamped. The header carries the
  // clamped value, so the receiver always gets exactly len_q words.
  always_comb begin
    if (32'(dpram_len) > 32'(DEPTH)) len_clamp = DEPTH;
    else                             len_clamp = LW'(dpram_len);
  end

  assign cnt_inc = cnt_q + 1'b1;
  assign hs      = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    word_d  = word_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    frame_d = frame_q;
    unique case (state_q)
      S_IDLE: begin
        if (dpram_run) begin
          len_d   = len_clamp;
          cnt_d   = '0;
          addr_d  = '0;
          busy_d  = 1'b1;
          // The header is presented on the cycle right after run.
          valid_d = 1'b1;
          data_d  = 16'(len_clamp);
          last_d  = (len_clamp == '0);
          state_d = S_HDR;
        end
      end
      S_HDR: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = (len_q == '0) ? S_DONE : S_RD;
        end
      end
      // The address was already set on the previous step. This cycle lets
      // the DPRAM register it.
      S_RD: state_d = S_LAT;
      S_LAT: begin
        word_d  = dpram_rd_data;
        valid_d = 1'b1;
        data_d  = dpram_rd_data[31:16];
        last_d  = 1'b0;
        state_d = S_HI;
      end
      S_HI: begin
        if (hs) begin
          data_d  = word_q[15:0];
          last_d  = (cnt_inc == len_q);
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (hs) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          cnt_d   = cnt_inc;
          // At full depth the last increment wraps to 0. No read follows.
          addr_d  = addr_q + 1'b1;
          state_d = (cnt_inc == len_q) ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        frame_d = frame_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      frame_q <= frame_d;
    end
  end

  assign dpram_busy    = busy_q;
  assign dpram_rd_addr = addr_q;
  assign out_data      = data_q;
  assign out_valid     = valid_q;
  assign out_last      = last_q;
  assign frame_cnt     = frame_q;

endmodule
